// File: rtl/mem_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_seq_ctrl : Moore sequencer for one read/write memory transaction     |
// |                with a wait-state counter and a timeout abort.            |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module mem_seq_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start_i,
  input  logic       write_i,
  input  logic       mem_ready_i,
  output logic       MARin_o,
  output logic       MDRin_o,
  output logic       MDRread_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] last_wait_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_MAR = 3'd1,
    S_LOAD_MDR = 3'd2,
    S_WAIT     = 3'd3,
    S_CAPTURE  = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  localparam logic [7:0] c_timeout      = 8'(TIMEOUT);
  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       op_q, op_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] last_wait_q, last_wait_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      cnt_q       <= 8'd0;
      last_wait_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      last_wait_q <= last_wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    last_wait_d = last_wait_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD_MAR;
          op_d    = write_i;
        end
      end
      S_LOAD_MAR: begin
        cnt_d   = 8'd0;
        state_d = op_q ? S_LOAD_MDR : S_WAIT;
      end
      S_LOAD_MDR: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a timeout on the same edge.
        if (mem_ready_i) begin
          state_d     = op_q ? S_DONE : S_CAPTURE;
          last_wait_d = cnt_q + 8'd1;
        end else if (cnt_q == c_timeout_last) begin
          state_d     = S_ERR;
          last_wait_d = c_timeout;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MARin_o   = 1'b0;
    MDRin_o   = 1'b0;
    MDRread_o = 1'b0;
    mem_rd_o  = 1'b0;
    mem_wr_o  = 1'b0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    busy_o    = (state_q != S_IDLE);
    case (state_q)
      S_LOAD_MAR: MARin_o = 1'b1;
      S_LOAD_MDR: MDRin_o = 1'b1;
      S_WAIT: begin
        mem_rd_o = ~op_q;
        mem_wr_o = op_q;
      end
      S_CAPTURE: begin
        MDRin_o   = 1'b1;
        MDRread_o = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      S_ERR:   err_o  = 1'b1;
      default: ;
    endcase
  end

  assign last_wait_o = last_wait_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_seq_ctrl : randomized self-checking bench for mem_seq_ctrl        |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_mem_seq_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       clr, start, write, mem_ready;
  logic       MARin, MDRin, MDRread, mem_rd, mem_wr, busy, done, err;
  logic [7:0] last_wait;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .clr         (clr),
    .start_i     (start),
    .write_i     (write),
    .mem_ready_i (mem_ready),
    .MARin_o     (MARin),
    .MDRin_o     (MDRin),
    .MDRread_o   (MDRread),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .last_wait_o (last_wait)
  );

  // Bit order: MARin MDRin MDRread mem_rd mem_wr busy done err
  function automatic logic [7:0] outs();
    return {MARin, MDRin, MDRread, mem_rd, mem_wr, busy, done, err};
  endfunction

  // One transaction from an idle negedge. d = WAIT cycles spent with
  // mem_ready low before it is raised; d >= TO means it never arrives.
  task automatic run_txn(input logic op, input int d, input string tag);
    logic [7:0] exp_q[$];
    int         widx_q[$];
    int         nw;
    bit         ok;
    nw = (d + 1 < TO) ? d + 1 : TO;
    ok = (d < TO);
    exp_q.push_back(8'b1000_0100); widx_q.push_back(-1);
    if (op) begin
      exp_q.push_back(8'b0100_0100); widx_q.push_back(-1);
    end
    for (int w = 0; w < nw; w++) begin
      exp_q.push_back(op ? 8'b0000_1100 : 8'b0001_0100);
      widx_q.push_back(w);
    end
    if (ok) begin
      if (!op) begin
        exp_q.push_back(8'b0110_0100); widx_q.push_back(-1);
      end
      exp_q.push_back(8'b0000_0110); widx_q.push_back(-1);
    end else begin
      exp_q.push_back(8'b0000_0101); widx_q.push_back(-1);
    end

    start     = 1'b1;
    write     = op;
    mem_ready = 1'($urandom);
    @(posedge clk);
    foreach (exp_q[i]) begin
      @(negedge clk);
      start = 1'($urandom);
      write = 1'($urandom);
      if (widx_q[i] >= 0) mem_ready = (widx_q[i] == d);
      else                mem_ready = 1'($urandom);
      total++;
      if (outs() !== exp_q[i]) begin
        bad++;
        $display("FAIL %s cyc%0d outs got %b want %b", tag, i, outs(), exp_q[i]);
      end
    end
    start = 1'b0;
    @(negedge clk);
    total++;
    if (outs() !== 8'h00) begin
      bad++;
      $display("FAIL %s idle outs got %b want 00000000", tag, outs());
    end
    total++;
    if (last_wait !== 8'(nw)) begin
      bad++;
      $display("FAIL %s last_wait got %0d want %0d", tag, last_wait, nw);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b1; write = 1'b1; mem_ready = 1'b1;
    #12;
    total++;
    if (outs() !== 8'h00) begin
      bad++;
      $display("FAIL reset outs got %b want 00000000", outs());
    end
    total++;
    if (last_wait !== 8'd0) begin
      bad++;
      $display("FAIL reset last_wait got %0d want 0", last_wait);
    end
    @(negedge clk);
    clr = 1'b0; start = 1'b0; write = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_read();         run_txn(1'b0, 0,   "read_fast");     endtask
  task automatic test_write();        run_txn(1'b1, 3,   "write_wait3");   endtask
  task automatic test_timeout();
    run_txn(1'b0, 100, "read_timeout");
    run_txn(1'b1, TO,  "write_timeout");
  endtask
  task automatic test_ready_at_limit(); run_txn(1'b0, TO - 1, "read_limit"); endtask

  task automatic test_clr_abort();
    start = 1'b1; write = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_rd !== 1'b1) begin
      bad++;
      $display("FAIL clr_pre mem_rd got %b want 1", mem_rd);
    end
    #2 clr = 1'b1;
    #1;
    total++;
    if (outs() !== 8'h00) begin
      bad++;
      $display("FAIL clr_async outs got %b want 00000000", outs());
    end
    total++;
    if (last_wait !== 8'd0) begin
      bad++;
      $display("FAIL clr_async last_wait got %0d want 0", last_wait);
    end
    @(negedge clk); clr = 1'b0;
    run_txn(1'b0, 2, "post_clr");
  endtask

  task automatic test_back_to_back();
    logic [7:0] e[10];
    e = '{8'b1000_0100, 8'b0001_0100, 8'b0110_0100, 8'b0000_0110, 8'b0000_0000,
          8'b1000_0100, 8'b0001_0100, 8'b0110_0100, 8'b0000_0110, 8'b0000_0000};
    start = 1'b1; write = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) start = 1'b0;
      total++;
      if (outs() !== e[i]) begin
        bad++;
        $display("FAIL b2b cyc%0d outs got %b want %b", i, outs(), e[i]);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_txn(1'($urandom), int'($urandom_range(0, 20)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_ready_at_limit();
    test_clr_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
